pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Stage sequencer for the 5-stage MIPS pipeline datapath. Generates per-stage rst/en for IF/ID/EXE/MEM/WB.
//  Handles the post-reset fill sequence, RAW data-hazard stalls, branch flushes and data-memory wait states.
//  Sits between the control unit, the datapath and the data-memory port. Trips a sticky fault on a memory timeout.
// PARAMETERS
//  RST_CYCLES   4    cycles all stages stay held in reset after rst deasserts (>=1)
//  MEM_TIMEOUT  16   max consecutive mem wait cycles before fault (>=1)
//  CNT_W        32   width of perf counters
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  inst_data_id   in   32  instruction in ID (rs=[25:21], rt=[20:16])
//  rs_used/rt_used in  1   control unit: ID instruction reads rs / rt
//  is_branch_id   in   1   control unit: pc_src_ctrl != PC_NEXT
//  is_branch_exe  in   1   from datapath
//  regw_addr_exe  in   5   from datapath
//  wb_wen_exe     in   1   from datapath
//  is_branch_mem  in   1   from datapath
//  regw_addr_mem  in   5   from datapath
//  wb_wen_mem     in   1   from datapath
//  mem_valid      in   1   MEM stage holds a valid instruction
//  mem_ren/mem_wen in  1   MEM-stage memory access request
//  mem_ack        in   1   memory completes access this cycle
//  {if,id,exe,mem,wb}_rst out 1 each  stage reset to datapath
//  {if,id,exe,mem,wb}_en  out 1 each  stage enable to datapath
//  fault          out  1   sticky memory-timeout flag
// BEHAVIOUR
//  FSM (registered): ST_RESET -> ST_RUN <-> ST_MEM_WAIT -> ST_FAULT. ST_FAULT exits only via rst.
//  Async rst: state=ST_RESET, rst_cnt=0, wait_cnt=0, fault=0, all *_rst=1, all *_en=0.
//  ST_RESET: all *_rst=1, *_en=0. rst_cnt counts up; when rst_cnt==RST_CYCLES-1, next state is ST_RUN.
//  All other outputs are combinational from state + inputs. Priority: FAULT > RESET > mem wait > data > control.
//  ST_RUN defaults: all *_rst=0, all *_en=1.
//  mem_stall = mem_valid & (mem_ren|mem_wen) & ~mem_ack.
//   Effect: if/id/exe/mem_en=0, wb_rst=1 (bubble into WB). Next state ST_MEM_WAIT, wait_cnt=1.
//  ST_MEM_WAIT: same outputs while ~mem_ack; wait_cnt++.
//   When mem_ack arrives: RUN outputs that cycle, wait_cnt=0, back to ST_RUN.
//   When wait_cnt==MEM_TIMEOUT & ~mem_ack: go to ST_FAULT.
//  Single-cycle memory: ack in the request cycle means zero stall.
//  data_stall = (rs_used & rs!=0 & ((wb_wen_exe & rs==regw_addr_exe) | (wb_wen_mem & rs==regw_addr_mem)))
//   | same for rt. Register $0 never hazards.
//   Effect: if_en=0, id_en=0, exe_rst=1 (bubble into EXE).
//   The WB-stage hazard needs no stall; the regfile write is visible to a same-cycle ID read.
//  Control (when no mem/data stall). Branches resolve in MEM, so the penalty is 3 bubbles.
//   is_branch_id | is_branch_exe gives if_en=0, id_rst=1.
//   is_branch_mem gives if_en=1 (PC loads the target), id_rst=1.
//   Cycle after branch leaves MEM: IF fetches the target.
//  Simultaneous data_stall with a branch in ID: the stall wins. The branch stays in ID; flushing starts when it issues.
//  ST_FAULT: all *_en=0, *_rst=0 (pipeline frozen for debug), fault=1.
//  rst mid-operation: immediate async return to the reset values. No partial memory access is retried.
// CONFIGURATION
//  PERF_CNT_EN defined: adds outputs stall_data_cnt, stall_ctrl_cnt, stall_mem_cnt [CNT_W-1:0].
//   Each counts cycles in ST_RUN/ST_MEM_WAIT where that stall cause is the winning cause.
//   Counters saturate at all-ones and reset to 0 on rst.
//  PERF_CNT_EN undefined: no counters, no ports. Stage-control behaviour is identical.
// STRUCTURE
//  State encodings (ST_RESET=0, ST_RUN=1, ST_MEM_WAIT=2, ST_FAULT=3) are localparams in mips_define.vh.
//  PC_NEXT etc. are already there.
//  Sub-module hazard_detect: combinational, produces data_stall from ID addresses and EXE/MEM write info.
//  Everything else stays in pipeline_ctrl.
// TESTING
//  Reset release, RST_CYCLES=4 -> all *_rst=1 for 4 clks after rst falls; 5th clk all *_en=1, *_rst=0.
//  add $3 in EXE, ID reads rs=$3 -> 1 cycle if_en=id_en=0, exe_rst=1. Repeats while $3 is in MEM; none at WB.
//  Write to $0 in EXE, ID reads $0 -> no stall.
//  beq in ID -> 3 cycles id_rst=1; if_en=0,0,1. Next fetched PC = branch target.
//  lw with mem_ack 3 cycles late -> 3 cycles if..mem_en=0, wb_rst=1, then resumes. stall_mem_cnt=3 with PERF_CNT_EN.
//  mem_ack never, MEM_TIMEOUT=16 -> fault=1 after 16 wait cycles, all *_en=0. rst clears fault.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stage sequencer.
//   state_t    : sequencer FSM encoding (RESET=0, RUN=1, MEM_WAIT=2, FAULT=3)
//   raw_hazard : tests one ID source register against the EXE/MEM write ports
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    // $0 is hard-wired to zero, so a write to it can never create a hazard.
    function automatic logic raw_hazard(
        input logic       used,
        input logic [4:0] src,
        input logic       wen_exe,
        input logic [4:0] waddr_exe,
        input logic       wen_mem,
        input logic [4:0] waddr_mem
    );
        return used && (src != 5'd0) &&
               ((wen_exe && (src == waddr_exe)) || (wen_mem && (src == waddr_mem)));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational RAW-hazard detector for the ID stage.
// Ports:
//   rs, rt                   in  source register numbers of the ID instruction
//   rs_used, rt_used         in  ID instruction actually reads rs / rt
//   regw_addr_exe, wb_wen_exe in destination / write-enable of the EXE instruction
//   regw_addr_mem, wb_wen_mem in destination / write-enable of the MEM instruction
//   data_stall               out ID must hold until the producer reaches WB
// A producer in WB needs no stall: the regfile write is visible to a same-cycle read.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic [4:0] regw_addr_exe,
    input  logic       wb_wen_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    output logic       data_stall
);

    assign data_stall =
        raw_hazard(rs_used, rs, wb_wen_exe, regw_addr_exe, wb_wen_mem, regw_addr_mem) |
        raw_hazard(rt_used, rt, wb_wen_exe, regw_addr_exe, wb_wen_mem, regw_addr_mem);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage sequencer for the 5-stage MIPS pipeline.
// Drives per-stage reset/enable for IF/ID/EXE/MEM/WB: post-reset fill, RAW stalls,
// branch flushes (branches resolve in MEM, 3 bubbles) and data-memory wait states.
// A memory access waiting more than MEM_TIMEOUT cycles freezes the pipeline and
// raises a sticky fault that only rst clears.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   inst_data_id, rs_used, rt_used   ID instruction and its register usage
//   is_branch_id/exe/mem             branch present in ID / EXE / MEM
//   regw_addr_exe/mem, wb_wen_exe/mem write-back info of EXE / MEM instructions
//   mem_valid, mem_ren, mem_wen, mem_ack  MEM-stage data-memory handshake
//   {if,id,exe,mem,wb}_rst/_en       stage resets / enables to the datapath
//   fault                            sticky memory-timeout flag
// Build option: PERF_CNT_EN adds saturating stall_data_cnt / stall_ctrl_cnt /
// stall_mem_cnt outputs counting cycles where each cause is the winning one.
//
// state       | meaning
// ST_RESET    | all stages held in reset for RST_CYCLES after rst falls
// ST_RUN      | normal flow; data / control stalls applied combinationally
// ST_MEM_WAIT | data-memory access outstanding, upstream frozen, WB gets bubbles
// ST_FAULT    | memory timeout; pipeline frozen until rst
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_data_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             is_branch_id,
    input  logic             is_branch_exe,
    input  logic [4:0]       regw_addr_exe,
    input  logic             wb_wen_exe,
    input  logic             is_branch_mem,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    input  logic             mem_valid,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             mem_ack,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] stall_data_cnt,
    output logic [CNT_W-1:0] stall_ctrl_cnt,
    output logic [CNT_W-1:0] stall_mem_cnt,
`endif
    output logic             fault
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic [WC_W-1:0] wait_cnt;
    logic            data_stall;
    logic            mem_stall;
    logic            mem_hold;

    // Opcode, rd, shamt and funct fields play no part in hazard detection.
    logic unused_inst;
    assign unused_inst = ^{inst_data_id[31:26], inst_data_id[15:0]};

    hazard_detect u_hazard_detect (
        .rs            (inst_data_id[25:21]),
        .rt            (inst_data_id[20:16]),
        .rs_used       (rs_used),
        .rt_used       (rt_used),
        .regw_addr_exe (regw_addr_exe),
        .wb_wen_exe    (wb_wen_exe),
        .regw_addr_mem (regw_addr_mem),
        .wb_wen_mem    (wb_wen_mem),
        .data_stall    (data_stall)
    );

    assign mem_stall = mem_valid & (mem_ren | mem_wen) & ~mem_ack;
    // In MEM_WAIT the access is already known to be outstanding; only ack matters.
    assign mem_hold  = ((state == ST_RUN) & mem_stall) | ((state == ST_MEM_WAIT) & ~mem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            rst_cnt  <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1))
                        state <= ST_RUN;
                    else
                        rst_cnt <= rst_cnt + 1'b1;
                end
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FAULT: fault <= 1'b1;
            endcase
        end
    end

    // Priority: fault > reset > memory wait > data hazard > control flush.
    always_comb begin
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        if_en   = 1'b1;
        id_en   = 1'b1;
        exe_en  = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
        case (state)
            ST_FAULT: begin
                {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
            end
            ST_RESET: begin
                {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
                {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_hold) begin
                    {if_en, id_en, exe_en, mem_en} = 4'b0000;
                    wb_rst = 1'b1;
                end else if (data_stall) begin
                    // A branch stuck behind the hazard stays in ID and flushes once it issues.
                    if_en   = 1'b0;
                    id_en   = 1'b0;
                    exe_rst = 1'b1;
                end else if (is_branch_id | is_branch_exe) begin
                    if_en  = 1'b0;
                    id_rst = 1'b1;
                end else if (is_branch_mem) begin
                    // PC loads the target this cycle; the wrong-path fetch in ID is dropped.
                    id_rst = 1'b1;
                end
            end
        endcase
    end

`ifdef PERF_CNT_EN
    logic active;
    logic win_data;
    logic win_ctrl;
    assign active   = (state == ST_RUN) | (state == ST_MEM_WAIT);
    assign win_data = active & ~mem_hold & data_stall;
    assign win_ctrl = active & ~mem_hold & ~data_stall &
                      (is_branch_id | is_branch_exe | is_branch_mem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_data_cnt <= '0;
            stall_ctrl_cnt <= '0;
            stall_mem_cnt  <= '0;
        end else begin
            if (mem_hold && (stall_mem_cnt != '1))
                stall_mem_cnt <= stall_mem_cnt + 1'b1;
            if (win_data && (stall_data_cnt != '1))
                stall_data_cnt <= stall_data_cnt + 1'b1;
            if (win_ctrl && (stall_ctrl_cnt != '1))
                stall_ctrl_cnt <= stall_ctrl_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // Stage-control patterns {if,id,exe,mem,wb}_rst , {if,id,exe,mem,wb}_en
    localparam logic [9:0] C_RESET = 10'b11111_00000;
    localparam logic [9:0] C_RUN   = 10'b00000_11111;
    localparam logic [9:0] C_MEM   = 10'b00001_00001;
    localparam logic [9:0] C_DATA  = 10'b00100_00111;
    localparam logic [9:0] C_BRE   = 10'b01000_01111;
    localparam logic [9:0] C_BRM   = 10'b01000_11111;
    localparam logic [9:0] C_FAULT = 10'b00000_00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_data_id = '0;
    logic        rs_used = 0, rt_used = 0;
    logic        is_branch_id = 0, is_branch_exe = 0, is_branch_mem = 0;
    logic [4:0]  regw_addr_exe = '0, regw_addr_mem = '0;
    logic        wb_wen_exe = 0, wb_wen_mem = 0;
    logic        mem_valid = 0, mem_ren = 0, mem_wen = 0, mem_ack = 0;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic        fault;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_data_cnt, stall_ctrl_cnt, stall_mem_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(.RST_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .inst_data_id(inst_data_id),
        .rs_used(rs_used), .rt_used(rt_used),
        .is_branch_id(is_branch_id), .is_branch_exe(is_branch_exe),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .is_branch_mem(is_branch_mem), .regw_addr_mem(regw_addr_mem),
        .wb_wen_mem(wb_wen_mem), .mem_valid(mem_valid), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_ack(mem_ack),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst),
        .wb_rst(wb_rst), .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en),
`ifdef PERF_CNT_EN
        .stall_data_cnt(stall_data_cnt), .stall_ctrl_cnt(stall_ctrl_cnt),
        .stall_mem_cnt(stall_mem_cnt),
`endif
        .fault(fault)
    );

    always #5 clk = ~clk;

    logic [9:0] ctrl;
    assign ctrl = {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en};

    typedef struct {
        logic [4:0] rs, rt;
        logic       ru, tu;
        logic [4:0] wa_exe;
        logic       we_exe;
        logic [4:0] wa_mem;
        logic       we_mem;
        logic       b_id, b_exe, b_mem;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic [9:0] exp);
        #1;
        check(name, {22'd0, ctrl}, {22'd0, exp});
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic ru, input logic tu);
        inst_data_id = {6'h23, rs, rt, 16'hbeef};
        rs_used = ru;
        rt_used = tu;
    endtask

    task automatic clear_inputs();
        set_id(5'd0, 5'd0, 1'b0, 1'b0);
        {is_branch_id, is_branch_exe, is_branch_mem} = 3'b000;
        regw_addr_exe = '0; wb_wen_exe = 0;
        regw_addr_mem = '0; wb_wen_mem = 0;
        {mem_valid, mem_ren, mem_wen, mem_ack} = 4'b0000;
    endtask

    // rst high across an edge, then release and walk the 4-cycle fill.
    task automatic reset_seq();
        rst = 1'b1;
        tick();
        check_ctrl("rst_held", C_RESET);
        check("rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_ctrl($sformatf("fill_c%0d", c), C_RESET);
            tick();
        end
        check_ctrl("fill_done", C_RUN);
`ifdef PERF_CNT_EN
        check("perf_rst_mem", stall_mem_cnt, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rs  rt ru tu waE weE waM weM bid bex bmem exp
        vecs[0]  = '{5'd3, 5'd4, 1, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, C_RUN};
        vecs[1]  = '{5'd3, 5'd4, 1, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0, C_DATA};
        vecs[2]  = '{5'd3, 5'd4, 1, 1, 5'd5, 1, 5'd3, 1, 0, 0, 0, C_DATA};
        vecs[3]  = '{5'd3, 5'd4, 1, 1, 5'd3, 0, 5'd3, 0, 0, 0, 0, C_RUN};
        vecs[4]  = '{5'd3, 5'd7, 1, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0, C_DATA};
        vecs[5]  = '{5'd3, 5'd7, 1, 0, 5'd5, 1, 5'd7, 1, 0, 0, 0, C_RUN};
        vecs[6]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, C_RUN};
        vecs[7]  = '{5'd3, 5'd4, 0, 1, 5'd3, 1, 5'd3, 1, 0, 0, 0, C_RUN};
        vecs[8]  = '{5'd3, 5'd4, 1, 1, 5'd5, 0, 5'd6, 0, 1, 0, 0, C_BRE};
        vecs[9]  = '{5'd3, 5'd4, 1, 1, 5'd5, 0, 5'd6, 0, 0, 1, 0, C_BRE};
        vecs[10] = '{5'd3, 5'd4, 1, 1, 5'd5, 0, 5'd6, 0, 0, 0, 1, C_BRM};
        vecs[11] = '{5'd3, 5'd4, 1, 1, 5'd3, 1, 5'd6, 0, 1, 0, 0, C_DATA};
        vecs[12] = '{5'd3, 5'd4, 1, 1, 5'd6, 0, 5'd4, 1, 0, 0, 1, C_DATA};

        clear_inputs();
        reset_seq();

        // Combinational stall/flush decode in ST_RUN.
        for (int i = 0; i < 13; i++) begin
            tick();
            set_id(vecs[i].rs, vecs[i].rt, vecs[i].ru, vecs[i].tu);
            regw_addr_exe = vecs[i].wa_exe; wb_wen_exe = vecs[i].we_exe;
            regw_addr_mem = vecs[i].wa_mem; wb_wen_mem = vecs[i].we_mem;
            {is_branch_id, is_branch_exe, is_branch_mem} = {vecs[i].b_id, vecs[i].b_exe, vecs[i].b_mem};
            check_ctrl($sformatf("vec%0d", i), vecs[i].exp);
        end

        // beq walking ID -> EXE -> MEM: if_en 0,0,1 with id_rst held.
        tick(); clear_inputs(); is_branch_id = 1;
        check_ctrl("beq_id", C_BRE);
        tick(); is_branch_id = 0; is_branch_exe = 1;
        check_ctrl("beq_exe", C_BRE);
        tick(); is_branch_exe = 0; is_branch_mem = 1;
        check_ctrl("beq_mem", C_BRM);
        tick(); is_branch_mem = 0;
        check_ctrl("beq_target", C_RUN);

        // lw acked 3 cycles late; a concurrent RAW hazard must lose to the memory wait.
        clear_inputs();
        reset_seq();
        tick();
        mem_valid = 1; mem_ren = 1; mem_ack = 0;
        set_id(5'd3, 5'd4, 1, 1); regw_addr_exe = 5'd3; wb_wen_exe = 1;
        check_ctrl("lw_wait0", C_MEM);
        tick(); check_ctrl("lw_wait1", C_MEM);
        tick(); check_ctrl("lw_wait2", C_MEM);
        tick(); mem_ack = 1; wb_wen_exe = 0;
        check_ctrl("lw_ack", C_RUN);
        tick(); clear_inputs();
        check_ctrl("lw_resume", C_RUN);
`ifdef PERF_CNT_EN
        check("perf_mem3", stall_mem_cnt, 32'd3);
        check("perf_data0", stall_data_cnt, 32'd0);
`endif
        is_branch_id = 1;
        check_ctrl("perf_br", C_BRE);
        tick(); is_branch_id = 0;
        set_id(5'd3, 5'd4, 1, 1); regw_addr_mem = 5'd4; wb_wen_mem = 1;
        check_ctrl("perf_data", C_DATA);
        tick(); clear_inputs();
`ifdef PERF_CNT_EN
        check("perf_ctrl1", stall_ctrl_cnt, 32'd1);
        check("perf_data1", stall_data_cnt, 32'd1);
        check("perf_mem_hold", stall_mem_cnt, 32'd3);
`endif

        // Single-cycle memory: ack with the request means no stall at all.
        mem_valid = 1; mem_wen = 1; mem_ack = 1;
        check_ctrl("sc_mem", C_RUN);
        tick(); clear_inputs();
        check_ctrl("sc_next", C_RUN);

        // Timeout: 1 request cycle in RUN + 16 MEM_WAIT cycles, then FAULT.
        tick();
        mem_valid = 1; mem_wen = 1; mem_ack = 0;
        check_ctrl("to_req", C_MEM);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_ctrl($sformatf("to_wait%0d", k), C_MEM);
            check($sformatf("to_nofault%0d", k), {31'd0, fault}, 32'd0);
        end
        tick();
        check_ctrl("to_fault_ctrl", C_FAULT);
        check("to_fault", {31'd0, fault}, 32'd1);
        mem_ack = 1;
        tick(); clear_inputs(); is_branch_mem = 1;
        check_ctrl("fault_sticky_ctrl", C_FAULT);
        check("fault_sticky", {31'd0, fault}, 32'd1);

        // Asynchronous rst mid-cycle clears the fault at once.
        clear_inputs();
        #2 rst = 1;
        check_ctrl("async_rst_ctrl", C_RESET);
        check("async_rst_fault", {31'd0, fault}, 32'd0);
        reset_seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
